// File: rtl/dir_pad_if.sv
// dir_pad_if: button inputs and direction outputs between board pins and snake core
interface dir_pad_if;
  logic [3:0] btn_raw;
  logic [3:0] direction;
  logic [1:0] moveway;
  logic dir_valid;
  logic [3:0] btn_level;
  modport master (output btn_raw, input direction, moveway, dir_valid, btn_level);
  modport slave (input btn_raw, output direction, moveway, dir_valid, btn_level);
endinterface

// File: rtl/dir_pad_encoder.sv
// dir_pad_encoder: debounced, arbitrated one-hot heading from four buttons; REVERSE_BLOCK_EN drops 180-degree reversals
module dir_pad_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input logic clk,
  input logic clear,
  dir_pad_if.slave pad
);
  typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} st_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] s1, s2, pe, level, opp, legal, dir_q;
  logic [1:0] win, mw_q;
  logic dv_q;
  // two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (clear) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad.btn_raw;
      s2 <= s1;
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_db
    st_t st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, inc;
    logic pe_q, lvl;
    assign inc = (cnt == '1) ? cnt : cnt + 1'b1;
    // state, counter and one-cycle press edge on entry to HELD
    always_ff @(posedge clk) begin
      if (clear) begin
        st <= IDLE;
        cnt <= '0;
        pe_q <= 1'b0;
      end else begin
        st <= st_nx;
        cnt <= cnt_nx;
        pe_q <= (st == PRESS) && (st_nx == HELD);
      end
    end
    // debounce transitions: a level is accepted after DEBOUNCE_CYCLES equal samples
    always_comb begin
      st_nx = st;
      cnt_nx = cnt;
      case (st)
        IDLE: if (s2[g]) begin
          st_nx = PRESS;
          cnt_nx = CNT_W'(1);
        end
        PRESS: if (!s2[g]) begin
          st_nx = IDLE;
          cnt_nx = '0;
        end else begin
          cnt_nx = inc;
          if (cnt == LAST) st_nx = HELD;
        end
        HELD: if (!s2[g]) begin
          st_nx = REL;
          cnt_nx = CNT_W'(1);
        end
        default: if (s2[g]) begin
          st_nx = HELD;
          cnt_nx = '0;
        end else begin
          cnt_nx = inc;
          if (cnt == LAST) st_nx = IDLE;
        end
      endcase
    end
    // debounced level is high while held or still confirming a release
    always_comb lvl = (st == HELD) || (st == REL);
    assign pe[g] = pe_q;
    assign level[g] = lvl;
  end
`ifdef REVERSE_BLOCK_EN
  assign opp = {dir_q[0], dir_q[1], dir_q[2], dir_q[3]};
`else
  assign opp = '0;
`endif
  assign legal = pe & ~opp;
  // priority right > left > down > up; bit index doubles as the moveway code
  always_comb win = legal[3] ? 2'd3 : legal[0] ? 2'd0 : legal[1] ? 2'd1 : 2'd2;
  // accept the winning edge one cycle after it appears
  always_ff @(posedge clk) begin
    if (clear) begin
      dir_q <= 4'b1000;
      mw_q <= 2'b11;
      dv_q <= 1'b0;
    end else begin
      dv_q <= |legal;
      if (|legal) begin
        dir_q <= 4'b0001 << win;
        mw_q <= win;
      end
    end
  end
  assign pad.direction = dir_q;
  assign pad.moveway = mw_q;
  assign pad.dir_valid = dv_q;
  assign pad.btn_level = level;
endmodule

// File: tb/tb_dir_pad_encoder.sv
// tb_dir_pad_encoder: directed checks of debounce, latency, arbitration and reversal handling
module tb_dir_pad_encoder;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int pulses, first, lvl;
  dir_pad_if pad ();
  dir_pad_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .clear(clear), .pad(pad));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input int bit_i, output int np, output int fst, output int lv);
    np = 0;
    fst = 0;
    lv = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pad.dir_valid) begin
        np++;
        if (fst == 0) fst = i;
      end
      if (pad.btn_level[bit_i]) lv = 1;
    end
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
  endtask
  initial begin
    pad.btn_raw = 4'b0000;
    tick();
    tick();
    check("rst_dir", 32'(pad.direction), 32'b1000);
    check("rst_mw", 32'(pad.moveway), 32'd3);
    check("rst_dv", 32'(pad.dir_valid), 32'd0);
    check("rst_lvl", 32'(pad.btn_level), 32'd0);
    clear = 1'b0;
    run(20, 0, pulses, first, lvl);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_dir", 32'(pad.direction), 32'b1000);
    check("idle_mw", 32'(pad.moveway), 32'd3);
    pad.btn_raw = 4'b0010;
    run(7, 1, pulses, first, lvl);
    check("down_latency", 32'(first), 32'd7);
    check("down_dir", 32'(pad.direction), 32'b0010);
    check("down_mw", 32'(pad.moveway), 32'd1);
    run(50, 1, pulses, first, lvl);
    check("down_hold_pulses", 32'(pulses), 32'd0);
    check("down_level", 32'(pad.btn_level), 32'b0010);
    pad.btn_raw = 4'b0000;
    run(12, 1, pulses, first, lvl);
    check("down_release_lvl", 32'(pad.btn_level), 32'd0);
    pad.btn_raw = 4'b0100;
    tick();
    tick();
    tick();
    pad.btn_raw = 4'b0000;
    run(15, 2, pulses, first, lvl);
    check("glitch_lvl", 32'(lvl), 32'd0);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_dir", 32'(pad.direction), 32'b0010);
    pad.btn_raw = 4'b0111;
    run(20, 0, pulses, first, lvl);
    check("multi_pulses", 32'(pulses), 32'd1);
    check("multi_dir", 32'(pad.direction), 32'b0001);
    check("multi_mw", 32'(pad.moveway), 32'd0);
    pad.btn_raw = 4'b0000;
    run(12, 0, pulses, first, lvl);
    check("repeat_setup_lvl", 32'(pad.btn_level), 32'd0);
    pad.btn_raw = 4'b0001;
    run(15, 0, pulses, first, lvl);
    check("repeat_pulses", 32'(pulses), 32'd1);
    check("repeat_dir", 32'(pad.direction), 32'b0001);
    pad.btn_raw = 4'b0000;
    run(12, 0, pulses, first, lvl);
    do_clear();
    check("rev_start_dir", 32'(pad.direction), 32'b1000);
    pad.btn_raw = 4'b0001;
    run(20, 0, pulses, first, lvl);
`ifdef REVERSE_BLOCK_EN
    check("rev_pulses", 32'(pulses), 32'd0);
    check("rev_dir", 32'(pad.direction), 32'b1000);
`else
    check("rev_pulses", 32'(pulses), 32'd1);
    check("rev_dir", 32'(pad.direction), 32'b0001);
`endif
    pad.btn_raw = 4'b0000;
    run(12, 0, pulses, first, lvl);
    do_clear();
    pad.btn_raw = 4'b0011;
    run(20, 0, pulses, first, lvl);
    check("rev_pair_pulses", 32'(pulses), 32'd1);
`ifdef REVERSE_BLOCK_EN
    check("rev_pair_dir", 32'(pad.direction), 32'b0010);
`else
    check("rev_pair_dir", 32'(pad.direction), 32'b0001);
`endif
    pad.btn_raw = 4'b0000;
    run(12, 0, pulses, first, lvl);
    do_clear();
    pad.btn_raw = 4'b0011;
    run(4, 0, pulses, first, lvl);
    check("mid_pulses", 32'(pulses), 32'd0);
    clear = 1'b1;
    tick();
    check("mid_clr_dir", 32'(pad.direction), 32'b1000);
    check("mid_clr_mw", 32'(pad.moveway), 32'd3);
    check("mid_clr_dv", 32'(pad.dir_valid), 32'd0);
    check("mid_clr_lvl", 32'(pad.btn_level), 32'd0);
    clear = 1'b0;
    run(7, 0, pulses, first, lvl);
    check("mid_latency", 32'(first), 32'd7);
`ifdef REVERSE_BLOCK_EN
    check("mid_dir", 32'(pad.direction), 32'b0010);
`else
    check("mid_dir", 32'(pad.direction), 32'b0001);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
